interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer.sv | 122 ++++++++++++
 tb/tb_interval_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// Programmable interval timer: three reloadable second-interval registers and a
// prescaled countdown that pulses once per second and once more on expiry.
module interval_timer #(
  parameter int         CLK_DIV  = 100_000_000,
  parameter logic [3:0] DEF_BASE = 4'd6,
  parameter logic [3:0] DEF_EXT  = 4'd3,
  parameter logic [3:0] DEF_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       sys_reset_n,
  input  logic       start_timer,
  input  logic [1:0] interval_address,
  input  logic       prg_sync_in,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic [3:0] seconds_left,
  output logic       one_hz_tick,
  output logic       o_dbg_state
);

  localparam int            PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_count;
  logic          r_expired;
  logic          r_tick;
  logic [3:0]    r_base;
  logic [3:0]    r_ext;
  logic [3:0]    r_yel;

  logic [3:0]    w_prog_val;
  logic [1:0]    w_eff_addr;
  logic [3:0]    w_sel_val;
  logic [3:0]    w_load_val;

  // A programmed zero is stored as one so an interval never collapses to nothing.
  assign w_prog_val = (time_value == 4'd0) ? 4'd1 : time_value;
  assign w_eff_addr = (interval_address == 2'b11) ? 2'b00 : interval_address;

  always_comb begin
    w_sel_val = r_base;
    case (w_eff_addr)
      2'b01:   w_sel_val = r_ext;
      2'b10:   w_sel_val = r_yel;
      default: w_sel_val = r_base;
    endcase
  end

  // A write landing on the same edge as the start is seen by that start.
  assign w_load_val = (prg_sync_in && (time_param_sel == w_eff_addr)) ? w_prog_val : w_sel_val;

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_base <= DEF_BASE;
      r_ext  <= DEF_EXT;
      r_yel  <= DEF_YEL;
    end else if (prg_sync_in) begin
      case (time_param_sel)
        2'b00:   r_base <= w_prog_val;
        2'b01:   r_ext  <= w_prog_val;
        2'b10:   r_yel  <= w_prog_val;
        default: ;
      endcase
    end
  end

  // start_timer overrides everything, including a tick that would expire the count.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_count   <= 4'd0;
      r_expired <= 1'b0;
      r_tick    <= 1'b0;
    end else if (start_timer) begin
      r_state   <= ST_COUNT;
      r_presc   <= '0;
      r_count   <= w_load_val;
      r_expired <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      case (r_state)
        ST_COUNT: begin
          r_expired <= 1'b0;
          r_tick    <= 1'b0;
          if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
              r_state   <= ST_IDLE;
              r_expired <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_presc   <= '0;
          r_count   <= 4'd0;
          r_expired <= 1'b0;
          r_tick    <= 1'b0;
        end
      endcase
    end
  end

  assign expired      = r_expired;
  assign one_hz_tick  = r_tick;
  assign seconds_left = r_count;
  assign o_dbg_state  = (r_state == ST_COUNT);

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: arithmetic reference model of countdown deadlines,
// expiry scoreboard queue, directed scenarios followed by random traffic.
module tb_interval_timer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval_address = 2'd0;
  logic       prg_sync_in = 1'b0;
  logic [1:0] time_param_sel = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       expired;
  logic [3:0] seconds_left;
  logic       one_hz_tick;
  logic       dbg_state;

  int vectors = 0;
  int miscompares = 0;

  interval_timer #(.CLK_DIV(DIV)) dut (
    .clk              (clk),
    .sys_reset_n      (sys_reset_n),
    .start_timer      (start_timer),
    .interval_address (interval_address),
    .prg_sync_in      (prg_sync_in),
    .time_param_sel   (time_param_sel),
    .time_value       (time_value),
    .expired          (expired),
    .seconds_left     (seconds_left),
    .one_hz_tick      (one_hz_tick),
    .o_dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: countdown described by start edge, length and deadline edge.
  logic [31:0] exp_q[$];
  int cyc = 0;
  int m_reg[3] = '{6, 3, 2};
  int m_active = 0;
  int m_start = 0;
  int m_n = 0;
  int m_done = -1;

  always @(posedge clk) begin : model
    int a;
    cyc++;
    m_done = -1;
    if (!sys_reset_n) begin
      m_reg = '{6, 3, 2};
      m_active = 0;
      exp_q.delete();
    end else begin
      if (prg_sync_in && time_param_sel != 2'd3)
        m_reg[time_param_sel] = (time_value == 4'd0) ? 1 : int'(time_value);
      if (start_timer) begin
        a = (interval_address == 2'd3) ? 0 : int'(interval_address);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        m_n = m_reg[a];
        m_start = cyc;
        m_active = 1;
        exp_q.push_back(32'(cyc + DIV * m_n));
      end else if (m_active != 0 && cyc == m_start + DIV * m_n) begin
        m_active = 0;
        m_done = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: expiry pulses are matched against the scoreboard queue.
  always @(negedge clk) begin : monitor
    logic exp_pulse;
    int el;
    int exp_sec;
    logic exp_tick;
    exp_pulse = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
    check("expired", {31'd0, expired}, {31'd0, exp_pulse});
    if (exp_pulse) void'(exp_q.pop_front());
    el = cyc - m_start;
    exp_sec = (m_active != 0) ? (m_n - el / DIV) : 0;
    exp_tick = ((m_active != 0) && el > 0 && (el % DIV) == 0) || (m_done == cyc);
    check("seconds_left", {28'd0, seconds_left}, 32'(exp_sec));
    check("one_hz_tick", {31'd0, one_hz_tick}, {31'd0, exp_tick});
    check("state", {31'd0, dbg_state}, 32'(m_active));
  end

  task automatic drive(input logic st, input logic [1:0] a, input logic pr,
                       input logic [1:0] sel, input logic [3:0] v);
    start_timer = st;
    interval_address = a;
    prg_sync_in = pr;
    time_param_sel = sel;
    time_value = v;
    @(negedge clk);
    start_timer = 1'b0;
    prg_sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int b = 0;
    while ((m_active != 0 || exp_q.size() > 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (b >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done at cycle %0d: countdown still pending after %0d cycles, required done", cyc, b);
    end
    idle(2);
  endtask

  task automatic do_reset();
    #2 sys_reset_n = 1'b0;
    #1;
    check("rst_expired", {31'd0, expired}, 32'd0);
    check("rst_seconds", {28'd0, seconds_left}, 32'd0);
    check("rst_tick", {31'd0, one_hz_tick}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    sys_reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    sys_reset_n = 1'b1;
    @(negedge clk);
    // Default BASE countdown
    drive(1, 2'd0, 0, 2'd0, 4'd0);
    wait_done();
    // Program EXT=9 then YEL=0 (stored as 1)
    drive(0, 2'd0, 1, 2'd1, 4'd9);
    drive(1, 2'd1, 0, 2'd0, 4'd0);
    wait_done();
    drive(0, 2'd0, 1, 2'd2, 4'd0);
    drive(1, 2'd2, 0, 2'd0, 4'd0);
    wait_done();
    // Restart six cycles into a 2 s countdown
    drive(0, 2'd0, 1, 2'd2, 4'd2);
    drive(1, 2'd2, 0, 2'd0, 4'd0);
    idle(5);
    drive(1, 2'd2, 0, 2'd0, 4'd0);
    wait_done();
    // Restart exactly on the expiring tick
    drive(1, 2'd2, 0, 2'd0, 4'd0);
    idle(2 * DIV - 1);
    drive(1, 2'd2, 0, 2'd0, 4'd0);
    wait_done();
    // Write-through on the starting edge
    drive(1, 2'd0, 1, 2'd0, 4'd3);
    wait_done();
    // Programming during a countdown only affects the next start
    drive(1, 2'd0, 0, 2'd0, 4'd0);
    idle(3);
    drive(0, 2'd0, 1, 2'd0, 4'd5);
    wait_done();
    drive(1, 2'd3, 0, 2'd0, 4'd0);
    wait_done();
    // Reset mid-count, then confirm defaults are back
    drive(1, 2'd1, 0, 2'd0, 4'd0);
    idle(10);
    do_reset();
    idle(20);
    drive(1, 2'd0, 0, 2'd0, 4'd0);
    wait_done();
    drive(1, 2'd1, 0, 2'd0, 4'd0);
    wait_done();
    drive(1, 2'd2, 0, 2'd0, 4'd0);
    wait_done();
    // Random traffic
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        do_reset();
      end else begin
        drive(logic'($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
              logic'($urandom_range(0, 99) < 35), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)));
      end
      idle(int'($urandom_range(0, 50)));
    end
    wait_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
